io_intc: RTL
============

Name: io_intc

Overview:
- Memory-mapped interrupt controller on the core's IO port (io_r/io_w/io_addr/io_wdata/io_rdata); drives the core's single `irq` input.
- Latches up to NSRC external sources as edge- or level-triggered pending bits and masks them with an enable register.
- The handler reads CLAIM to take the highest-priority source and writes COMPLETE to release it.
- Sits beside stage_mem on the IO bus.

Parameters:
- NSRC, 8, number of interrupt sources (1..31).
- BASE, 16'h0100, IO window base address; must be 32-byte aligned.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active-low.
- src  in  NSRC  raw interrupt source levels, asynchronous to clk.
- io_r  in  1  IO read strobe from core.
- io_w  in  1  IO write strobe from core.
- io_addr  in  16  IO byte address.
- io_wdata  in  32  IO write data.
- io_rdata  out  32  IO read data, combinational.
- irq  out  1  interrupt request to core, registered.

Behaviour:
- Clock and reset:
  - Single clock domain.
  - rst low clears PENDING, ENABLE, EDGE, INSVC, sync/prev flops and irq to 0 immediately.
  - io_rdata is 0 during reset because all state is 0.
- Address decode:
  - Window hit when io_addr[15:5]==BASE[15:5].
  - Offsets within the window:
    - 0x00 PENDING
    - 0x04 ENABLE
    - 0x08 EDGE
    - 0x0C CLAIM
    - 0x10 COMPLETE
    - 0x14 RAW
  - io_addr[1:0] ignored.
  - Miss or unmapped offset: io_rdata=0, writes ignored.
  - Bits >= NSRC read 0 and ignore writes.
- Reads:
  - io_rdata is combinational from io_addr when io_r=1, else 0.
  - Read side effects commit at the clock edge where io_r=1 and the window hits.
- Register semantics:
  - PENDING R/W1C. W1C affects edge sources only.
  - Level source pending bit equals its synchronized level every cycle and cannot be written.
  - ENABLE and EDGE are R/W; EDGE bit 1 = edge-triggered (rising), 0 = level.
  - Changing EDGE from 1 to 0 makes the pending bit follow the level from the next cycle.
  - RAW is read-only and returns the synchronized levels.
- Edge detection:
  - s = synchronized src; prev = s registered.
  - Edge source pending bit set at the clock edge where s & ~prev.
  - Set wins over a simultaneous W1C or claim-clear of the same bit.
- CLAIM read:
  - cand = PENDING & ENABLE & ~INSVC.
  - Returns {27'b0, id+1} for the lowest-index set bit of cand (lowest index = highest priority), or 0 if cand==0.
  - At that edge, when nonzero: INSVC[id] set; PENDING[id] cleared if edge source (unless re-set same cycle).
- COMPLETE write:
  - io_wdata[4:0]=id+1 clears INSVC[id].
  - Value 0 or >NSRC ignored.
  - A COMPLETE write and a CLAIM read cannot coincide (single IO port).
- irq:
  - irq <= |(PENDING & ENABLE & ~INSVC), registered, one cycle after the condition.
  - irq is a level and stays high while any candidate exists.
- Latency, src rise to irq high:
  - 2 clock edges without INTC_SYNC_EN.
  - 4 clock edges with INTC_SYNC_EN.
- Mid-operation reset clears all in-service state. An outstanding COMPLETE after reset is harmless.

Optional Feature:
- INTC_SYNC_EN defined: each src bit passes a two-flop synchronizer before edge/level logic; RAW and edge detection use the synchronizer output.
- INTC_SYNC_EN undefined: s=src directly (sources are assumed already synchronous); only the prev flop remains.

Decomposition:
- Shared package intc_pkg:
  - Register offset localparams (INTC_PENDING..INTC_RAW).
  - INTC_MAX_SRC=31.
  - Typedef intc_id_t (logic [4:0]).
- One sub-module, intc_src: per-source synchronizer (under INTC_SYNC_EN), prev flop and rising-edge pulse output. Instantiated NSRC times via generate.
- Top io_intc holds the registers, priority encoder, decode and irq flop.

Test Plan:
- Reset: hold rst=0 with src=8'hFF → irq=0, all registers read 0. Release; ENABLE=0 → irq stays 0.
- Edge path: EDGE=8'h04, ENABLE=8'h04, pulse src[2] one cycle → PENDING reads 8'h04; irq=1 after 2 edges (4 with INTC_SYNC_EN). CLAIM reads 3, then PENDING=0, irq drops next cycle. COMPLETE write 3 → INSVC clear.
- Priority: edge sources 1 and 5 pending and enabled → CLAIM=2, then CLAIM=6, then CLAIM=0 while both in service.
- Level path: EDGE=0, ENABLE=8'h01, src[0] held high → CLAIM=1. irq stays 0 while in service. COMPLETE 1 with src[0] still high → irq=1 next cycle.
- Collision: W1C PENDING=8'h08 in the same cycle src[3] edge is detected → PENDING[3] remains 1.
- Decode: read io_addr=BASE+0x18 or BASE+0x20 → 0. Write ENABLE=32'hFFFF_FFFF with NSRC=8 → reads 32'h0000_00FF. COMPLETE 0 or 9 → no INSVC change.

Source files
------------

// File: rtl/intc_pkg.sv
// Shared definitions for the io_intc interrupt controller: register offsets,
// source-id type and the priority-encoder helper.
package intc_pkg;

    localparam int INTC_MAX_SRC = 31;

    typedef logic [4:0] intc_id_t;

    // Byte offsets inside the 32-byte IO window (bits [1:0] are ignored by decode).
    localparam logic [4:0] INTC_PENDING  = 5'h00;
    localparam logic [4:0] INTC_ENABLE   = 5'h04;
    localparam logic [4:0] INTC_EDGE     = 5'h08;
    localparam logic [4:0] INTC_CLAIM    = 5'h0C;
    localparam logic [4:0] INTC_COMPLETE = 5'h10;
    localparam logic [4:0] INTC_RAW      = 5'h14;

    // Returns index+1 of the lowest set bit (highest priority), or 0 when empty.
    function automatic intc_id_t intc_first_id(input logic [INTC_MAX_SRC-1:0] vec);
        intc_id_t id;
        id = '0;
        for (int i = INTC_MAX_SRC - 1; i >= 0; i--) begin
            if (vec[i]) id = intc_id_t'(i + 1);
        end
        return id;
    endfunction

endpackage

// File: rtl/io_intc_if.sv
// Core IO port as seen by the interrupt controller: strobes, address, data.
interface io_intc_if;

    logic        io_r;
    logic        io_w;
    logic [15:0] io_addr;
    logic [31:0] io_wdata;
    logic [31:0] io_rdata;

    modport master (output io_r, output io_w, output io_addr, output io_wdata, input io_rdata);
    modport slave  (input io_r, input io_w, input io_addr, input io_wdata, output io_rdata);

endinterface

// File: rtl/intc_src.sv
// Per-source front end: optional two-flop synchronizer (INTC_SYNC_EN),
// previous-level flop and rising-edge pulse.
module intc_src (
    input  logic clk,
    input  logic rst,
    input  logic src_i,
    output logic lvl_o,
    output logic rise_o
);

    logic prev_q, prev_d;

`ifdef INTC_SYNC_EN
    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;

    always_comb begin
        sync1_d = src_i;
        sync2_d = sync1_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

    assign lvl_o = sync2_q;
`else
    assign lvl_o = src_i;
`endif

    always_comb prev_d = lvl_o;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) prev_q <= 1'b0;
        else      prev_q <= prev_d;
    end

    assign rise_o = lvl_o & ~prev_q;

endmodule

// File: rtl/io_intc.sv
// Memory-mapped interrupt controller on the core IO port. Optional input
// synchronizers per source are enabled with the INTC_SYNC_EN macro.
module io_intc
    import intc_pkg::*;
#(
    parameter int          NSRC = 8,
    parameter logic [15:0] BASE = 16'h0100
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NSRC-1:0] src,
    io_intc_if.slave        io,
    output logic            irq
);

    logic [NSRC-1:0] lvl, rise;

    for (genvar g = 0; g < NSRC; g++) begin : g_src
        intc_src u_src (
            .clk    (clk),
            .rst    (rst),
            .src_i  (src[g]),
            .lvl_o  (lvl[g]),
            .rise_o (rise[g])
        );
    end

    logic [NSRC-1:0] pending_q, pending_d;
    logic [NSRC-1:0] enable_q, enable_d;
    logic [NSRC-1:0] edge_sel_q, edge_sel_d;
    logic [NSRC-1:0] insvc_q, insvc_d;
    logic            irq_q, irq_d;

    logic                    hit, rd_en, wr_en;
    logic [4:0]              off;
    logic [NSRC-1:0]         cand, w1c, claim_vec, cpl_vec;
    logic [INTC_MAX_SRC-1:0] cand_ext;
    intc_id_t                claim_id, cpl_id;
    logic                    claim_fire, cpl_fire;
    logic [31:0]             rdata;
    logic                    unused_io_bits;

    assign hit   = (io.io_addr[15:5] == BASE[15:5]);
    assign off   = {io.io_addr[4:2], 2'b00};
    assign rd_en = io.io_r & hit;
    assign wr_en = io.io_w & hit;

    assign cand       = pending_q & enable_q & ~insvc_q;
    assign cand_ext   = INTC_MAX_SRC'(cand);
    assign claim_id   = intc_first_id(cand_ext);
    assign claim_fire = rd_en && (off == INTC_CLAIM) && (claim_id != '0);
    assign cpl_id     = io.io_wdata[4:0];
    assign cpl_fire   = wr_en && (off == INTC_COMPLETE);
    assign w1c        = (wr_en && off == INTC_PENDING) ? io.io_wdata[NSRC-1:0] : '0;

    assign unused_io_bits = ^{io.io_addr[1:0], io.io_wdata};

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        claim_vec = '0;
        cpl_vec   = '0;
        for (int i = 0; i < NSRC; i++) begin
            claim_vec[i] = claim_fire && (claim_id == intc_id_t'(i + 1));
            cpl_vec[i]   = cpl_fire && (cpl_id == intc_id_t'(i + 1));
        end
    end

    always_comb begin
        enable_d   = enable_q;
        edge_sel_d = edge_sel_q;
        pending_d  = pending_q;
        insvc_d    = (insvc_q | claim_vec) & ~cpl_vec;
        irq_d      = |cand;

        if (wr_en && off == INTC_ENABLE) enable_d   = io.io_wdata[NSRC-1:0];
        if (wr_en && off == INTC_EDGE)   edge_sel_d = io.io_wdata[NSRC-1:0];

        // A fresh rising edge wins over a W1C or claim-clear in the same cycle.
        for (int i = 0; i < NSRC; i++) begin
            if (edge_sel_q[i]) pending_d[i] = (pending_q[i] & ~w1c[i] & ~claim_vec[i]) | rise[i];
            else               pending_d[i] = lvl[i];
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pending_q  <= '0;
            enable_q   <= '0;
            edge_sel_q <= '0;
            insvc_q    <= '0;
            irq_q      <= 1'b0;
        end else begin
            pending_q  <= pending_d;
            enable_q   <= enable_d;
            edge_sel_q <= edge_sel_d;
            insvc_q    <= insvc_d;
            irq_q      <= irq_d;
        end
    end

    // Gating on rst keeps RAW (unsynchronized src) from leaking out during reset.
    always_comb begin
        rdata = '0;
        if (rd_en && rst) begin
            case (off)
                INTC_PENDING: rdata = 32'(pending_q);
                INTC_ENABLE:  rdata = 32'(enable_q);
                INTC_EDGE:    rdata = 32'(edge_sel_q);
                INTC_CLAIM:   rdata = 32'(claim_id);
                INTC_RAW:     rdata = 32'(lvl);
                default:      rdata = '0;
            endcase
        end
    end

    assign io.io_rdata = rdata;
    assign irq         = irq_q;

endmodule
